vga_timing_pipe: RTL
====================

Name: vga_timing_pipe

Overview:
- Pixel-timing generator and output pipeline for the VGA path.
- Sits directly upstream of the VGA output pins and the Wishbone-mapped VGA register/framebuffer block, on the VGA_CLK domain.
- Walks the 800x525 raster, issues per-pixel fetch requests (pix_x, pix_y, pix_req) to framebuffer RAM, and accepts pixel data FETCH_LAT cycles later.
- Delays sync and blanking to match that latency and drives registered, blank-gated 4:4:4 RGB plus HSYNC/VSYNC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, HSYNC asserted level
VS_POL, 0, VSYNC asserted level
FETCH_LAT, 2, cycles from pix_req to valid pix_data (range 1..4)

Ports:
VGA_CLK  in  1  pixel clock (25.175 MHz nominal)
VGA_RST  in  1  asynchronous, active-low reset
enable  in  1  raster run enable (synchronous)
pix_x  out  10  fetch column (h counter)
pix_y  out  10  fetch row (v counter)
pix_req  out  1  fetch strobe; high when (pix_x,pix_y) is visible
pix_data  in  12  {R[11:8],G[7:4],B[3:0]}, valid FETCH_LAT cycles after pix_req
frame_start  out  1  one-cycle pulse at h=0,v=0 while enabled
VGA_R_LED  out  4  red
VGA_G_LED  out  4  green
VGA_B_LED  out  4  blue
VGA_HSYNC  out  1  horizontal sync
VGA_VSYNC  out  1  vertical sync

Behaviour:
- Reset (VGA_RST=0, async assert, sync release):
  - h_cnt = 0, v_cnt = 0; all delay-line stages cleared.
  - pix_req = 0, frame_start = 0, RGB = 0.
  - HSYNC = ~HS_POL, VSYNC = ~VS_POL (deasserted).
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters, with enable=1:
  - h_cnt increments each clock; wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0 on the same edge that h_cnt wraps.
- enable=0: counters synchronously forced to 0 and held; pix_req = 0; frame_start = 0. The delay line keeps shifting blank/deasserted values, so outputs go black with syncs deasserted within FETCH_LAT+1 cycles.
- pix_x = h_cnt, pix_y = v_cnt; both registered, so no extra latency.
- pix_req = enable & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- frame_start = enable & h_cnt==0 & v_cnt==0.
- Raw sync terms, computed at counter stage:
  - hs_raw true for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw true for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Delay line: {pix_req, hs_raw, vs_raw} shifted FETCH_LAT stages, then one output register stage.
- Output stage, applied at the clock edge FETCH_LAT+1 after the counter cycle:
  - RGB = act_d ? pix_data : 0.
  - HSYNC = hs_d ? HS_POL : ~HS_POL; VSYNC likewise with VS_POL.
- Total latency: counter state -> pins = FETCH_LAT+1 clocks, identical for RGB and both syncs (no skew).
- pix_data is ignored (RGB forced 0) whenever the delayed active flag is 0, including X values from RAM.
- Enable toggled mid-frame: raster restarts at (0,0) on re-enable with frame_start on the first enabled cycle. No partial-line recovery.
- Reset mid-frame: immediate async clear as above; no glitch beyond reset assertion.
- Widths: counters 10 bits; H_TOTAL-1 and V_TOTAL-1 must be < 1024.

Test Plan:
- Reset then enable=1, run 2 frames -> frame_start pulses exactly every 420000 clocks; first pulse on the first enabled cycle.
- Line check -> per line, pix_req high 640 consecutive clocks; HSYNC low 96 clocks starting 656+FETCH_LAT+1 clocks after h=0.
- Frame check -> VSYNC low for exactly 2 lines (1600 clocks), beginning when v_cnt=490, h_cnt=0, delayed 3 clocks (FETCH_LAT=2).
- RAM model returns pix_data = {pix_x[3:0], pix_y[3:0], 4'hA} with latency 2 -> RGB at pins matches the expected value for each pixel; RGB = 0 in all blanking intervals.
- Drop enable at h=300, v=100 for 50 clocks, then raise -> within 3 clocks RGB = 0 and syncs = 1; on re-enable, pix_x = 0, pix_y = 0 and frame_start pulses.
- Assert VGA_RST low asynchronously mid-line (between clock edges) -> RGB = 0 and HSYNC/VSYNC = 1 immediately; after release, raster restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_pipe_if.sv
// Framebuffer fetch port between the VGA timing pipe (master) and the framebuffer RAM (slave).
// The master presents (pix_x, pix_y, pix_req); the slave answers with pix_data FETCH_LAT clocks later.
interface vga_timing_pipe_if;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_req;
   logic [11:0] pix_data;

   modport master (
      output pix_x,
      output pix_y,
      output pix_req,
      input  pix_data
   );

   modport slave (
      input  pix_x,
      input  pix_y,
      input  pix_req,
      output pix_data
   );
endinterface

// File: rtl/vga_timing_pipe.sv
// VGA raster timing generator with a fetch-latency-matched output stage.
// Counters issue framebuffer fetches; blank/sync flags ride a delay line so RGB and syncs leave aligned.
module vga_timing_pipe #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int FETCH_LAT = 2
) (
   input  logic              VGA_CLK,
   input  logic              VGA_RST,
   input  logic              enable,
   vga_timing_pipe_if.master fetch,
   output logic              frame_start,
   output logic [3:0]        VGA_R_LED,
   output logic [3:0]        VGA_G_LED,
   output logic [3:0]        VGA_B_LED,
   output logic              VGA_HSYNC,
   output logic              VGA_VSYNC
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic       HS_ON    = 1'(HS_POL);
   localparam logic       VS_ON    = 1'(VS_POL);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       run;

   // Reset gates the combinational strobes so nothing is requested while held in reset.
   assign run = enable & VGA_RST;

   always_comb begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (enable) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
         end
      end
   end

   always_ff @(posedge VGA_CLK or negedge VGA_RST) begin
      if (!VGA_RST) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   logic act_raw;
   logic hs_raw;
   logic vs_raw;

   always_comb begin
      act_raw = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_raw  = run && (h_cnt_q >= HS_FIRST) && (h_cnt_q < HS_STOP);
      vs_raw  = run && (v_cnt_q >= VS_FIRST) && (v_cnt_q < VS_STOP);
   end

   assign fetch.pix_x   = h_cnt_q;
   assign fetch.pix_y   = v_cnt_q;
   assign fetch.pix_req = act_raw;
   assign frame_start   = run && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

   // Delay line: one stage per clock of fetch latency, so flags meet pix_data at the output register.
   logic [FETCH_LAT-1:0] act_dly_q, act_dly_d;
   logic [FETCH_LAT-1:0] hs_dly_q,  hs_dly_d;
   logic [FETCH_LAT-1:0] vs_dly_q,  vs_dly_d;

   generate
      for (genvar gi = 0; gi < FETCH_LAT; gi++) begin : g_dly
         if (gi == 0) begin : g_head
            assign act_dly_d[gi] = act_raw;
            assign hs_dly_d[gi]  = hs_raw;
            assign vs_dly_d[gi]  = vs_raw;
         end else begin : g_tail
            assign act_dly_d[gi] = act_dly_q[gi-1];
            assign hs_dly_d[gi]  = hs_dly_q[gi-1];
            assign vs_dly_d[gi]  = vs_dly_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge VGA_CLK or negedge VGA_RST) begin
      if (!VGA_RST) begin
         act_dly_q <= '0;
         hs_dly_q  <= '0;
         vs_dly_q  <= '0;
      end else begin
         act_dly_q <= act_dly_d;
         hs_dly_q  <= hs_dly_d;
         vs_dly_q  <= vs_dly_d;
      end
   end

   logic act_late;
   logic hs_late;
   logic vs_late;

   assign act_late = act_dly_q[FETCH_LAT-1];
   assign hs_late  = hs_dly_q[FETCH_LAT-1];
   assign vs_late  = vs_dly_q[FETCH_LAT-1];

   logic [11:0] rgb_q, rgb_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;

   // Blanked pixels never look at pix_data, so undefined RAM output cannot reach the pins.
   always_comb begin
      rgb_d   = act_late ? fetch.pix_data : 12'h000;
      hsync_d = hs_late ? HS_ON : ~HS_ON;
      vsync_d = vs_late ? VS_ON : ~VS_ON;
   end

   always_ff @(posedge VGA_CLK or negedge VGA_RST) begin
      if (!VGA_RST) begin
         rgb_q   <= 12'h000;
         hsync_q <= ~HS_ON;
         vsync_q <= ~VS_ON;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign VGA_R_LED = rgb_q[11:8];
   assign VGA_G_LED = rgb_q[7:4];
   assign VGA_B_LED = rgb_q[3:0];
   assign VGA_HSYNC = hsync_q;
   assign VGA_VSYNC = vsync_q;
endmodule
